mux_pn_rr: RTL

- Parametrised N:1 registered multiplexer with a valid/ready handshake on every input channel and on the output.
- Two modes:
  - SELECT: forward the channel chosen by `sel`.
  - ROUND_ROBIN: fair arbitration among valid channels.
- Generalises the 2:1 combinational mux to N channels of WIDTH bits, with one cycle of registered latency and backpressure.
- Sits between multiple producers and a single downstream consumer in datapath test structures.

---
 rtl/mux_pn_rr_pkg.sv | 18 +
 rtl/mux_pn_rr_rr_arbiter_n.sv | 31 +++
 rtl/mux_pn_rr.sv | 119 +++++++++++
 3 files changed

// File: rtl/mux_pn_rr_pkg.sv
// Shared definitions for the mux_pn_rr registered N:1 multiplexer:
// mode encodings, output-register states and the parity helper.
package mux_pkg;

  localparam logic MODE_SELECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Even parity of up to 64 bits; callers zero-extend narrower words.
  function automatic logic even_parity(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/mux_pn_rr_rr_arbiter_n.sv
// Combinational rotate-priority encoder: grants the first asserted request
// found scanning ptr, ptr+1, ... modulo N.
module rr_arbiter_n
  import mux_pkg::*;
#(
  parameter int N = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             en,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  int unsigned idx;

  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (en && !gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_pn_rr.sv
// Registered N:1 mux with valid/ready on every channel, SELECT or ROUND_ROBIN
// grant. Define MUX_PN_PARITY_EN to add the registered out_parity output.
module mux_pn_rr
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_ch
`ifdef MUX_PN_PARITY_EN
  ,
  output logic               out_parity
`endif
);

  out_state_e        state_q, state_d;
  logic [WIDTH-1:0]  data_q;
  logic [SEL_W-1:0]  ch_q;
  logic [SEL_W-1:0]  rr_ptr_q;

  logic              load_ok;
  logic              sel_hit;
  logic [SEL_W-1:0]  arb_idx;
  logic              arb_vld;
  logic [SEL_W-1:0]  gnt_idx;
  logic              gnt_vld;
  logic              transfer;
  logic [WIDTH-1:0]  gnt_data;

  rr_arbiter_n #(.N(N)) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr_q),
    .en      (mode == MODE_RR),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  assign load_ok = (state_q == ST_EMPTY) | out_ready;

  // Out-of-range sel (non power-of-two N) simply yields no grant.
  always_comb begin
    sel_hit = 1'b0;
    if (32'(sel) < 32'(N)) sel_hit = in_valid[sel];
  end

  always_comb begin
    if (mode == MODE_SELECT) begin
      gnt_idx = sel;
      gnt_vld = sel_hit;
    end else begin
      gnt_idx = arb_idx;
      gnt_vld = arb_vld;
    end
  end

  assign transfer = gnt_vld & load_ok;
  assign gnt_data = in_data[int'(gnt_idx)*WIDTH +: WIDTH];

  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < N; i++) begin
      in_ready[i] = transfer && (32'(gnt_idx) == i);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (transfer) state_d = ST_FULL;
      ST_FULL:  if (out_ready && !transfer) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      data_q   <= '0;
      ch_q     <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      if (transfer) begin
        data_q <= gnt_data;
        ch_q   <= gnt_idx;
        if (mode == MODE_RR) begin
          rr_ptr_q <= (32'(gnt_idx) == 32'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
    end
  end

  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign out_valid = (state_q == ST_FULL);

`ifdef MUX_PN_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        parity_q <= 1'b0;
    else if (transfer) parity_q <= even_parity(64'(gnt_data));
  end

  assign out_parity = parity_q;
`endif

endmodule
